// File: rtl/bnna_pkg.sv
// Shared widths and types for the binary neural network popcount datapath.
package bnna_pkg;
   localparam int PCNT_W = 8;
   localparam int WORD_W = 64;
   localparam int ACC_W  = 16;

   typedef logic signed [PCNT_W-1:0] pcnt_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/act_packer.sv
// Packs one activation bit per completed neuron into an N_ACT-wide word and
// emits it when full or on flush; a flush never emits an empty word.
module act_packer
   import bnna_pkg::*;
#(
   parameter int N_ACT = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             act_we,
   input  logic             act_bit,
   input  logic             flush,
   output logic [N_ACT-1:0] stream_o,
   output logic             o_val
);
   localparam int ACNT_W = (N_ACT > 1) ? $clog2(N_ACT) : 1;

   logic [N_ACT-1:0]  pack;
   logic [N_ACT-1:0]  pack_next;
   logic [ACNT_W-1:0] act_cnt;
   logic              emit;

   always_comb begin
      pack_next = pack;
      if (act_we) pack_next[act_cnt] = act_bit;
   end

   // A completing activation is folded in before the flush decision, so a
   // flush that coincides with a full word still produces a single emission.
   assign emit = (act_we && (act_cnt == ACNT_W'(N_ACT-1))) ||
                 (flush && ((act_cnt != '0) || act_we));

   always_ff @(posedge clk) begin
      if (rst) begin
         pack     <= '0;
         act_cnt  <= '0;
         stream_o <= '0;
         o_val    <= 1'b0;
      end else begin
         o_val <= emit;
         if (emit) begin
            stream_o <= pack_next;
            pack     <= '0;
            act_cnt  <= '0;
         end else if (act_we) begin
            pack    <= pack_next;
            act_cnt <= act_cnt + ACNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/popcount_acc.sv
// Accumulates signed popcount words per neuron, thresholds the sum and packs
// activations. Define POPCOUNT_ACC_SUM_EN to expose each final sum on sum_o/sum_val.
module popcount_acc
   import bnna_pkg::*;
#(
   parameter int N_WORDS = 4,
   parameter int N_ACT   = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       stream_i,
   input  logic             i_val,
   input  logic [15:0]      thr_i,
   input  logic             flush_i,
   output logic [N_ACT-1:0] stream_o,
   output logic             o_val
`ifdef POPCOUNT_ACC_SUM_EN
   ,
   output acc_t             sum_o,
   output logic             sum_val
`endif
);
   // Handshake: i_val is a pure valid with no backpressure; a word is taken on
   // every rising edge with i_val=1. o_val is a one-cycle pulse, no ready.
   localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   acc_t             acc;
   acc_t             sum;
   logic [CNT_W-1:0] word_cnt;
   logic             last_word;
   logic             act_bit;

   assign sum       = acc + acc_t'({{(ACC_W-PCNT_W){stream_i[PCNT_W-1]}}, stream_i});
   assign last_word = i_val && (word_cnt == CNT_W'(N_WORDS-1));
   assign act_bit   = (sum >= acc_t'(thr_i));

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         word_cnt <= '0;
      end else if (flush_i || last_word) begin
         acc      <= '0;
         word_cnt <= '0;
      end else if (i_val) begin
         acc      <= sum;
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end

`ifdef POPCOUNT_ACC_SUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_o   <= '0;
         sum_val <= 1'b0;
      end else begin
         sum_val <= last_word;
         if (last_word) sum_o <= sum;
      end
   end
`endif

   act_packer #(.N_ACT(N_ACT)) u_packer (
      .clk      (clk),
      .rst      (rst),
      .act_we   (last_word),
      .act_bit  (act_bit),
      .flush    (flush_i),
      .stream_o (stream_o),
      .o_val    (o_val)
   );
endmodule

// File: doc/popcount_acc.md
POPCOUNT_ACC -- requirements
Module: popcount_acc

Interface
REQ-001 Parameter N_WORDS, default 4, SHALL be the popcount words per neuron; legal range 1..256.
REQ-002 Parameter N_ACT, default 64, SHALL be the activations packed per output word.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 stream_i  input  8  SHALL carry the signed popcount result (2*popcount-64, range -64..+64, two's complement).
REQ-006 i_val  input  1  SHALL qualify stream_i; the word is accepted on any rising edge where i_val=1.
REQ-007 thr_i  input  16  SHALL carry the signed neuron threshold, sampled only with the final word of a neuron.
REQ-008 flush_i  input  1  SHALL request emission of a partially filled activation word.
REQ-009 stream_o  output  N_ACT  SHALL carry packed binary activations, activation n in bit n.
REQ-010 o_val  output  1  SHALL pulse high for exactly one cycle per emitted stream_o.

Function
REQ-011 Accumulator SHALL be 16-bit signed; stream_i sign-extended; no overflow possible within the legal N_WORDS range.
REQ-012 Word counter 0..N_WORDS-1 SHALL advance on each accepted word and wrap to 0 after the final word.
REQ-013 On the final word: sum = acc + stream_i; activation = (sum >= thr_i), signed compare; acc cleared to 0 on the same edge.
REQ-014 Activation SHALL be written to the pack register at index act_cnt on the edge the final word is accepted.
REQ-015 When act_cnt = N_ACT-1 and an activation is written, stream_o SHALL be registered on that edge with o_val=1 visible the next cycle (latency 1 from last-word accept), and act_cnt wraps to 0.
REQ-016 Cycles with i_val=0 SHALL leave acc, counters and pack register unchanged; gaps of any length are legal.
REQ-017 flush_i=1 with act_cnt>0 SHALL emit the pack register, unwritten bits 0, with o_val next cycle; act_cnt cleared.
REQ-018 flush_i=1 with act_cnt=0 and no activation completing that cycle SHALL produce no o_val.
REQ-019 flush_i coincident with a neuron-completing word SHALL include that activation in the emitted word; only one o_val SHALL result even if that word also fills index N_ACT-1.
REQ-020 flush_i SHALL discard any partial neuron (acc and word counter cleared), including a non-final word accepted that cycle.
REQ-021 stream_o SHALL hold its last emitted value while o_val=0.

Reset
REQ-022 rst SHALL clear acc, word counter, act_cnt, pack register, stream_o to 0 and o_val to 0 on the next edge, overriding i_val and flush_i.
REQ-023 Reset mid-neuron or mid-word SHALL discard all partial state; the first word accepted after rst falls starts neuron 0 at pack index 0.

Configuration
REQ-024 Macro POPCOUNT_ACC_SUM_EN defined: ports sum_o (output, 16, final signed sum) and sum_val (output, 1) SHALL be present, sum_val pulsing one cycle after each neuron completes with sum_o holding that sum.
REQ-025 Macro undefined: sum_o and sum_val SHALL be absent and behaviour otherwise identical.

Structure
REQ-026 Shared package bnna_pkg SHALL hold PCNT_W=8, WORD_W=64, ACC_W=16 and typedefs pcnt_t, acc_t (signed).
REQ-027 The pack register, act_cnt and flush handling SHALL be a sub-module act_packer; accumulation and threshold stay in popcount_acc.

Verification (N_WORDS=4, N_ACT=64)
REQ-028 64 neurons of 4x stream_i=0x40, thr_i=0 -> stream_o=0xFFFF_FFFF_FFFF_FFFF, single o_val one cycle after the 256th word.
REQ-029 4x stream_i=0xC0 (sum -256): thr_i=-256 -> activation 1; thr_i=-255 -> activation 0 (check via flush or sum_o=0xFF00).
REQ-030 64 neurons alternating thr_i=0/+1 with words 0x00 -> stream_o=0x5555_5555_5555_5555.
REQ-031 3 neurons giving 1,0,1 then flush_i -> stream_o=0x5, o_val one cycle; second flush immediately after -> no o_val.
REQ-032 rst asserted after 2 words of a neuron, then 4x 0x40, thr_i=256, flush -> stream_o=0x1 (sum exactly 256).
REQ-033 Random i_val gaps (0-5 cycles) over 128 neurons -> outputs match gap-free run bit-for-bit, exactly 2 o_val pulses.
